// File: rtl/te_smooth_filter_pipe.sv
// te_smooth_filter_pipe
// ---------------------------------------------------------------------------
// Three-stage pipelined 3x3 smoothing filter for the transmission-estimate
// path.  Each window carries its own kernel mode: passthrough, 1-2-1 2-D
// Gaussian, vertical-only 1-2-1 or horizontal-only 1-2-1.  Results can be
// rounded half-up or truncated at elaboration time.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_valid   window and mode valid this cycle
//   in_ready   block accepts a window this cycle (low only while stalled)
//   in_mode    kernel select: 0 pass, 1 gauss2d, 2 vert, 3 horiz
//   in_win     packed 3x3 window, row-major, pixel 1 (top-left) in the LSBs
//   out_valid  filtered pixel valid
//   out_ready  downstream accepts the pixel
//   out_pix    filtered pixel
//   out_mode   mode that travelled with this pixel's window
// ---------------------------------------------------------------------------
module te_smooth_filter_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter bit ROUND      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [9*DATA_WIDTH-1:0] in_win,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_pix,
    output logic [1:0]              out_mode
);

    localparam int PW = DATA_WIDTH + 3;
    localparam int SW = DATA_WIDTH + 4;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_VERT  = 2'd2;
    localparam logic [1:0] MODE_HORIZ = 2'd3;

    logic                    advance;

    logic                    s1_valid;
    logic [1:0]              s1_mode;
    logic [9*DATA_WIDTH-1:0] s1_win;

    logic [PW-1:0]           c [9];
    logic [PW-1:0]           p1, p2, p3;

    logic                    s2_valid;
    logic [1:0]              s2_mode;
    logic [PW-1:0]           s2_r1, s2_r2, s2_r3;

    logic [SW-1:0]           sum_rnd;
    logic [DATA_WIDTH-1:0]   result;

    // The whole pipeline moves as one: the only thing that can stop it is a
    // result sitting at the output that downstream has not taken yet.  Bubbles
    // are deliberately not squeezed out, so a stall freezes every stage.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Stage 1 simply registers the incoming window and its mode.  The window
    // is only overwritten on a real transfer so the data lines hold steady
    // across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 2'd0;
            s1_win   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_win  <= in_win;
            end
        end
    end

    // Break the captured window into nine zero-extended pixels, wide enough
    // that the x2 and x4 weighted terms can be summed without overflow.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            c[i] = PW'(s1_win[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Three partial sums per mode.  For the 1-D kernels and passthrough the
    // taps are steered into the same three slots so stage 3 is a single
    // three-input adder regardless of mode; passthrough just parks the
    // centre pixel in the first slot.
    always_comb begin
        p1 = '0;
        p2 = '0;
        p3 = '0;
        case (s1_mode)
            MODE_PASS: begin
                p1 = c[4];
            end
            MODE_GAUSS: begin
                p1 = c[0] + (c[1] << 1) + c[2];
                p2 = (c[3] << 1) + (c[4] << 2) + (c[5] << 1);
                p3 = c[6] + (c[7] << 1) + c[8];
            end
            MODE_VERT: begin
                p1 = c[1];
                p2 = c[4] << 1;
                p3 = c[7];
            end
            MODE_HORIZ: begin
                p1 = c[3];
                p2 = c[4] << 1;
                p3 = c[5];
            end
            default: begin
                p1 = '0;
            end
        endcase
    end

    // Stage 2 registers the partial sums along with the mode so the final
    // stage knows which shift to apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 2'd0;
            s2_r1    <= '0;
            s2_r2    <= '0;
            s2_r3    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_r1   <= p1;
                s2_r2   <= p2;
                s2_r3   <= p3;
            end
        end
    end

    // Final add plus the half-LSB rounding term, then the shift is done by
    // picking the right bit field.  The Gaussian weights sum to 16 and the
    // 1-D kernels to 4, so the selected field always fits DATA_WIDTH bits.
    always_comb begin
        sum_rnd = SW'(s2_r1) + SW'(s2_r2) + SW'(s2_r3);
        if (ROUND) begin
            if (s2_mode == MODE_GAUSS) begin
                sum_rnd = sum_rnd + SW'(8);
            end else if (s2_mode != MODE_PASS) begin
                sum_rnd = sum_rnd + SW'(2);
            end
        end
        case (s2_mode)
            MODE_GAUSS: result = sum_rnd[DATA_WIDTH+3:4];
            MODE_VERT,
            MODE_HORIZ: result = sum_rnd[DATA_WIDTH+1:2];
            default:    result = sum_rnd[DATA_WIDTH-1:0];
        endcase
    end

    // Stage 3 is the output register.  On a bubble only out_valid drops;
    // the pixel and mode hold their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_mode  <= 2'd0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_pix  <= result;
                out_mode <= s2_mode;
            end
        end
    end

endmodule

// File: tb/tb_te_smooth_filter_pipe.sv
// Testbench for te_smooth_filter_pipe.  Two instances share all inputs, one
// built with rounding and one with truncation, both at a 10-bit pixel width.
// A reference model computes each kernel from its weights with plain integer
// arithmetic and tracks which windows are in flight.
module tb_te_smooth_filter_pipe;

    localparam int DW = 10;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [1:0]      in_mode;
    logic [9*DW-1:0] in_win;
    logic            out_ready;

    logic            in_ready_a, in_ready_b;
    logic            out_valid_a, out_valid_b;
    logic [DW-1:0]   out_pix_a, out_pix_b;
    logic [1:0]      out_mode_a, out_mode_b;

    te_smooth_filter_pipe #(.DATA_WIDTH(DW), .ROUND(1'b1)) dut_rnd (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_mode(in_mode), .in_win(in_win),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_pix(out_pix_a), .out_mode(out_mode_a)
    );

    te_smooth_filter_pipe #(.DATA_WIDTH(DW), .ROUND(1'b0)) dut_trn (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_mode(in_mode), .in_win(in_win),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pix(out_pix_b), .out_mode(out_mode_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            v;
        logic [DW-1:0] pix_rnd;
        logic [DW-1:0] pix_trn;
        logic [1:0]    mode;
    } slot_t;

    slot_t pipe [3];
    int    cur [9];
    int    n_checks;
    int    n_fail;
    int    n_acc;
    int    n_emit;
    bit    last_in_xfer;

    // Reference kernel: weighted sum from the kernel definition, then divide
    // with optional round-half-up.
    function automatic int ref_pix(input int c [9], input int mode, input bit rnd);
        int w [3];
        int s;
        int div;
        w[0] = 1; w[1] = 2; w[2] = 1;
        s = 0;
        div = 1;
        case (mode)
            0: begin s = c[4]; div = 1; end
            1: begin
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        s += w[r] * w[k] * c[3*r + k];
                div = 16;
            end
            2: begin s = c[1] + 2*c[4] + c[7]; div = 4; end
            default: begin s = c[3] + 2*c[4] + c[5]; div = 4; end
        endcase
        if (div == 1) return s;
        return rnd ? (s + div/2) / div : s / div;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input int mode);
        in_valid = v;
        in_mode  = mode[1:0];
        for (int i = 0; i < 9; i++) in_win[i*DW +: DW] = cur[i][DW-1:0];
    endtask

    task automatic setWindow(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        cur[0] = a0; cur[1] = a1; cur[2] = a2;
        cur[3] = a3; cur[4] = a4; cur[5] = a5;
        cur[6] = a6; cur[7] = a7; cur[8] = a8;
    endtask

    // Compare both instances against the model slot at the output.
    task automatic checkOutput(input bit stall);
        checkVal("in_ready_rnd",  in_ready_a,  !stall);
        checkVal("in_ready_trn",  in_ready_b,  !stall);
        checkVal("out_valid_rnd", out_valid_a, pipe[2].v);
        checkVal("out_valid_trn", out_valid_b, pipe[2].v);
        if (pipe[2].v) begin
            checkVal("out_pix_rnd",  out_pix_a,  pipe[2].pix_rnd);
            checkVal("out_pix_trn",  out_pix_b,  pipe[2].pix_trn);
            checkVal("out_mode_rnd", out_mode_a, pipe[2].mode);
            checkVal("out_mode_trn", out_mode_b, pipe[2].mode);
        end
    endtask

    // One clock: check outputs mid-cycle, take the edge, advance the model.
    task automatic cycle(input bit chk);
        bit stall;
        bit in_x;
        bit out_x;
        #1;
        stall = pipe[2].v && !out_ready;
        in_x  = in_valid && !stall;
        out_x = pipe[2].v && out_ready;
        if (chk) checkOutput(stall);
        last_in_xfer = in_x;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
            n_acc  = 0;
            n_emit = 0;
        end else begin
            if (in_x)  n_acc++;
            if (out_x) n_emit++;
            if (!stall) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0].v = in_valid;
                if (in_valid) begin
                    pipe[0].pix_rnd = DW'(ref_pix(cur, int'(in_mode), 1'b1));
                    pipe[0].pix_trn = DW'(ref_pix(cur, int'(in_mode), 1'b0));
                    pipe[0].mode    = in_mode;
                end
            end
        end
        #1;
    endtask

    // Single window into an empty pipe; the result must show up after the
    // transfer cycle plus two more, with the given constant values.
    task automatic sendOne(input string tag, input int mode, input int exp_rnd, input int exp_trn);
        applyStimulus(1'b1, mode);
        cycle(1'b1);
        applyStimulus(1'b0, 0);
        cycle(1'b1);
        cycle(1'b1);
        #1;
        checkVal({tag, "_valid"},    out_valid_a, 1'b1);
        checkVal({tag, "_pix_rnd"},  out_pix_a,   exp_rnd);
        checkVal({tag, "_pix_trn"},  out_pix_b,   exp_trn);
        checkVal({tag, "_mode"},     out_mode_a,  mode);
        cycle(1'b1);
    endtask

    initial begin
        int i;
        int budget;
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        n_emit   = 0;
        for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
        for (int k = 0; k < 9; k++) cur[k] = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 0);
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        #1;
        checkVal("reset_in_ready",  in_ready_a,  1'b1);
        checkVal("reset_out_valid", out_valid_a, 1'b0);
        checkVal("reset_out_pix",   out_pix_a,   0);
        checkVal("reset_out_mode",  out_mode_a,  0);
        cycle(1'b1);

        $display("[TB] directed kernels");
        setWindow(100, 100, 100, 100, 100, 100, 100, 100, 100);
        sendOne("flat100_gauss", 1, 100, 100);
        setWindow(0, 1, 2, 3, 4, 5, 6, 7, 8);
        sendOne("ramp_pass",  0, 4, 4);
        sendOne("ramp_gauss", 1, 4, 4);
        sendOne("ramp_vert",  2, 4, 4);
        sendOne("ramp_horiz", 3, 4, 4);
        setWindow(0, 0, 0, 0, 255, 0, 0, 0, 0);
        sendOne("spike_gauss", 1, 64, 63);
        sendOne("spike_vert",  2, 128, 127);
        sendOne("spike_horiz", 3, 128, 127);
        setWindow(255, 255, 255, 255, 255, 255, 255, 255, 255);
        sendOne("flat255_gauss", 1, 255, 255);
        setWindow(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023);
        sendOne("flatmax_gauss", 1, 1023, 1023);
        sendOne("flatmax_vert",  2, 1023, 1023);

        $display("[TB] back-to-back stream with stall");
        i = 0;
        budget = 0;
        while (i < 10 && budget < 40) begin
            for (int k = 0; k < 9; k++) cur[k] = 10*i + k;
            applyStimulus(1'b1, i % 4);
            out_ready = !(budget >= 6 && budget < 10);
            #1;
            checkVal("stream_in_ready", in_ready_a, out_ready);
            cycle(1'b1);
            if (last_in_xfer) i++;
            budget++;
        end
        checkVal("stream_done", i, 10);
        applyStimulus(1'b0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle(1'b1);
        checkVal("stream_count", n_emit, n_acc);

        $display("[TB] reset with pixels in flight");
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 9; k++) cur[k] = $urandom_range(0, 1023);
            applyStimulus(1'b1, j + 1);
            cycle(1'b1);
        end
        applyStimulus(1'b0, 0);
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        #1;
        checkVal("midreset_out_valid", out_valid_a, 1'b0);
        checkVal("midreset_out_pix",   out_pix_a,   0);
        checkVal("midreset_out_mode",  out_mode_b,  0);
        for (int k = 0; k < 4; k++) cycle(1'b1);
        setWindow(0, 0, 0, 0, 255, 0, 0, 0, 0);
        sendOne("postreset_gauss", 1, 64, 63);

        $display("[TB] random valid/ready traffic");
        budget = 0;
        while (n_acc < 1000 && budget < 8000) begin
            for (int k = 0; k < 9; k++) cur[k] = $urandom_range(0, (1 << DW) - 1);
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 3));
            out_ready = $urandom_range(0, 99) < 65;
            cycle(1'b1);
            budget++;
        end
        checkVal("random_accepted", n_acc >= 1000, 1'b1);
        applyStimulus(1'b0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle(1'b1);
        checkVal("random_count", n_emit, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
